// File: rtl/npem_capability_regs.sv
// NPEM extended capability register block with a command handshake to the enclosure controller.
// Control writes raise a pending command that is issued as a single valid/ready transaction, with a timeout.
module npem_capability_regs #(
  parameter int          REGISTER_WIDTH = 32,
  parameter logic [3:0]  CAP_VERSION    = 4'h1,
  parameter logic [9:0]  SUPPORTED_IND  = 10'h3FF,
  parameter logic        RESET_CAPABLE  = 1'b1,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [11:0]               next_capability_offset,
  input  logic                      cfg_wr_en,
  input  logic                      cfg_rd_en,
  input  logic [1:0]                cfg_addr,
  input  logic [REGISTER_WIDTH-1:0] cfg_wr_data,
  input  logic [3:0]                cfg_byte_en,
  output logic [REGISTER_WIDTH-1:0] cfg_rd_data,
  output logic                      cfg_rd_valid,
  output logic [REGISTER_WIDTH-1:0] npem_cmd,
  output logic                      npem_cmd_valid,
  input  logic                      npem_cmd_ready,
  output logic                      cmd_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  // Initiate Reset (bit 1) is stored so it reaches the command, but never reads back.
  localparam logic [31:0] WR_MASK = {20'h0, SUPPORTED_IND, RESET_CAPABLE, 1'b1};
  localparam logic [31:0] RD_MASK = {20'h0, SUPPORTED_IND, 1'b0, 1'b1};

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [31:0]       ctrl_reg, ctrl_next;
  logic [31:0]       cmd_reg, cmd_next;
  logic              valid_reg, valid_next;
  logic              timeout_reg, timeout_next;
  logic              pending_reg, pending_next;
  logic              cc_reg, cc_next;
  logic [31:0]       rd_data_reg, rd_data_next;
  logic              rd_valid_reg;

  logic [31:0] be_mask;
  logic        ctrl_wr, ctrl_kick, cc_clr, cc_set, issue;

  for (genvar gi = 0; gi < 4; gi++) begin : g_be
    assign be_mask[gi*8 +: 8] = {8{cfg_byte_en[gi]}};
  end

  assign ctrl_wr   = cfg_wr_en && (cfg_addr == 2'd2);
  assign ctrl_kick = ctrl_wr && (cfg_byte_en[0] || cfg_byte_en[1]);
  assign cc_clr    = cfg_wr_en && (cfg_addr == 2'd3) && cfg_byte_en[0] && cfg_wr_data[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      ctrl_reg     <= '0;
      cmd_reg      <= '0;
      valid_reg    <= 1'b0;
      timeout_reg  <= 1'b0;
      pending_reg  <= 1'b0;
      cc_reg       <= 1'b0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      ctrl_reg     <= ctrl_next;
      cmd_reg      <= cmd_next;
      valid_reg    <= valid_next;
      timeout_reg  <= timeout_next;
      pending_reg  <= pending_next;
      cc_reg       <= cc_next;
      rd_data_reg  <= rd_data_next;
      rd_valid_reg <= cfg_rd_en;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    cmd_next     = cmd_reg;
    valid_next   = valid_reg;
    timeout_next = 1'b0;
    cc_set       = 1'b0;
    issue        = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (pending_reg) begin
          state_next = BUSY;
          cmd_next   = ctrl_reg;
          valid_next = 1'b1;
          cnt_next   = '0;
          issue      = 1'b1;
        end
      end
      BUSY: begin
        if (npem_cmd_ready) begin
          state_next = IDLE;
          valid_next = 1'b0;
          cnt_next   = '0;
          cc_set     = 1'b1;
        end else if (cnt_reg == CNT_LAST) begin
          state_next   = IDLE;
          valid_next   = 1'b0;
          cnt_next     = '0;
          cc_set       = 1'b1;
          timeout_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // A write landing on the issue edge re-arms pending so it is not lost.
    pending_next = ctrl_kick ? 1'b1 : (issue ? 1'b0 : pending_reg);
    ctrl_next    = ctrl_wr ? ((ctrl_reg & ~(WR_MASK & be_mask)) | (cfg_wr_data & WR_MASK & be_mask))
                           : ctrl_reg;
    cc_next      = cc_set ? 1'b1 : (cc_clr ? 1'b0 : cc_reg);

    rd_data_next = rd_data_reg;
    if (cfg_rd_en) begin
      unique case (cfg_addr)
        2'd0:    rd_data_next = {next_capability_offset, CAP_VERSION, 16'h0029};
        2'd1:    rd_data_next = {20'h0, SUPPORTED_IND, RESET_CAPABLE, 1'b1};
        2'd2:    rd_data_next = ctrl_reg & RD_MASK;
        default: rd_data_next = {31'h0, cc_reg};
      endcase
    end
  end

  assign cfg_rd_data    = rd_data_reg;
  assign cfg_rd_valid   = rd_valid_reg;
  assign npem_cmd       = cmd_reg;
  assign npem_cmd_valid = valid_reg;
  assign cmd_timeout    = timeout_reg;

endmodule

// File: tb/tb_npem_capability_regs.sv
// Bench for npem_capability_regs: instance a uses default parameters, instance b a reduced
// indication mask with a short timeout; both share the stimulus.
module tb_npem_capability_regs;

  localparam logic [31:0] A_WM = 32'h0000_0FFF;
  localparam logic [31:0] A_RM = 32'h0000_0FFD;
  localparam logic [31:0] B_WM = 32'h0000_0017;
  localparam logic [31:0] B_RM = 32'h0000_0015;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] next_off = 12'h0;
  logic        wr_en = 1'b0, rd_en = 1'b0, ready = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  be = 4'h0;

  logic [31:0] a_rd_data, a_cmd, b_rd_data, b_cmd;
  logic        a_rd_valid, a_valid, a_timeout, b_rd_valid, b_valid, b_timeout;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  npem_capability_regs u_a (
    .clk(clk), .rst_n(rst_n), .next_capability_offset(next_off),
    .cfg_wr_en(wr_en), .cfg_rd_en(rd_en), .cfg_addr(addr), .cfg_wr_data(wdata),
    .cfg_byte_en(be), .cfg_rd_data(a_rd_data), .cfg_rd_valid(a_rd_valid),
    .npem_cmd(a_cmd), .npem_cmd_valid(a_valid), .npem_cmd_ready(ready),
    .cmd_timeout(a_timeout)
  );

  npem_capability_regs #(.SUPPORTED_IND(10'h005), .TIMEOUT_CYCLES(8)) u_b (
    .clk(clk), .rst_n(rst_n), .next_capability_offset(next_off),
    .cfg_wr_en(wr_en), .cfg_rd_en(rd_en), .cfg_addr(addr), .cfg_wr_data(wdata),
    .cfg_byte_en(be), .cfg_rd_data(b_rd_data), .cfg_rd_valid(b_rd_valid),
    .npem_cmd(b_cmd), .npem_cmd_valid(b_valid), .npem_cmd_ready(ready),
    .cmd_timeout(b_timeout)
  );

  // Byte-masked register write rule applied to a model value.
  function automatic logic [31:0] apply_wr(input logic [31:0] old, input logic [31:0] d,
                                           input logic [3:0] e, input logic [31:0] wm);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (e[b]) r[b*8 +: 8] = d[b*8 +: 8] & wm[b*8 +: 8];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ad, input logic [31:0] d, input logic [3:0] e);
    wr_en = 1'b1; addr = ad; wdata = d; be = e;
    step();
    wr_en = 1'b0; be = 4'h0;
  endtask

  task automatic rd(input logic [1:0] ad);
    rd_en = 1'b1; addr = ad;
    step();
    rd_en = 1'b0;
  endtask

  task automatic ack();
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  task automatic apply_reset();
    ready = 1'b0; wr_en = 1'b0; rd_en = 1'b0; be = 4'h0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({a_rd_data, a_rd_valid, a_cmd, a_valid, a_timeout} !== 98'h0) begin
      bad++; $display("FAIL reset_a_outputs: got %h want 0", {a_rd_data, a_rd_valid, a_cmd, a_valid, a_timeout});
    end
    total++;
    if ({b_rd_data, b_rd_valid, b_cmd, b_valid, b_timeout} !== 98'h0) begin
      bad++; $display("FAIL reset_b_outputs: got %h want 0", {b_rd_data, b_rd_valid, b_cmd, b_valid, b_timeout});
    end
    rd(2'd2);
    total++;
    if (a_rd_data !== 32'h0) begin bad++; $display("FAIL reset_ctrl: got %h want 0", a_rd_data); end
    rd(2'd3);
    total++;
    if (a_rd_data !== 32'h0) begin bad++; $display("FAIL reset_status: got %h want 0", a_rd_data); end
  endtask

  task automatic test_header_read();
    next_off = 12'h150;
    rd(2'd0);
    total++;
    if (a_rd_data !== 32'h1501_0029 || a_rd_valid !== 1'b1) begin
      bad++; $display("FAIL hdr_read: got %h valid %b want 15010029 valid 1", a_rd_data, a_rd_valid);
    end
    step();
    total++;
    if (a_rd_valid !== 1'b0) begin bad++; $display("FAIL hdr_valid_pulse: got %b want 0", a_rd_valid); end
    rd(2'd1);
    total++;
    if (a_rd_data !== A_WM) begin bad++; $display("FAIL cap_a: got %h want %h", a_rd_data, A_WM); end
    total++;
    if (b_rd_data !== B_WM) begin bad++; $display("FAIL cap_b: got %h want %h", b_rd_data, B_WM); end
    wr(2'd1, 32'h0, 4'hF);
    rd(2'd1);
    total++;
    if (b_rd_data !== B_WM) begin bad++; $display("FAIL cap_readonly: got %h want %h", b_rd_data, B_WM); end
  endtask

  task automatic test_ctrl_write();
    apply_reset();
    wr(2'd2, 32'hFFFF_FFFF, 4'hF);
    total++;
    if (b_valid !== 1'b0) begin bad++; $display("FAIL ctrl_early_valid: got %b want 0", b_valid); end
    step();
    total++;
    if (b_valid !== 1'b1 || b_cmd !== 32'h0000_0017) begin
      bad++; $display("FAIL ctrl_cmd_b: got %h valid %b want 00000017 valid 1", b_cmd, b_valid);
    end
    total++;
    if (a_valid !== 1'b1 || a_cmd !== A_WM) begin
      bad++; $display("FAIL ctrl_cmd_a: got %h valid %b want %h valid 1", a_cmd, a_valid, A_WM);
    end
    rd(2'd2);
    total++;
    if (b_rd_data !== 32'h0000_0015) begin bad++; $display("FAIL ctrl_read_b: got %h want 00000015", b_rd_data); end
    total++;
    if (a_rd_data !== A_RM) begin bad++; $display("FAIL ctrl_read_a: got %h want %h", a_rd_data, A_RM); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (b_valid !== 1'b1 || b_cmd !== 32'h0000_0017) begin
        bad++; $display("FAIL ctrl_hold: got %h valid %b want 00000017 valid 1", b_cmd, b_valid);
      end
    end
    ack();
    total++;
    if (b_valid !== 1'b0 || b_timeout !== 1'b0) begin
      bad++; $display("FAIL ctrl_ack: got valid %b timeout %b want 0 0", b_valid, b_timeout);
    end
    rd(2'd3);
    total++;
    if (b_rd_data !== 32'h1) begin bad++; $display("FAIL cc_set: got %h want 1", b_rd_data); end
    wr(2'd3, 32'h1, 4'h1);
    rd(2'd3);
    total++;
    if (b_rd_data !== 32'h0) begin bad++; $display("FAIL cc_w1c: got %h want 0", b_rd_data); end
    // Upper bytes alone must not start a command.
    wr(2'd2, 32'hFFFF_FFFF, 4'hC);
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (a_valid !== 1'b0) begin bad++; $display("FAIL upper_be_no_cmd: got %b want 0", a_valid); end
    end
  endtask

  task automatic test_coalesce();
    int extra;
    apply_reset();
    wr(2'd2, 32'h1, 4'hF);
    step();
    total++;
    if (a_valid !== 1'b1 || a_cmd !== 32'h1) begin
      bad++; $display("FAIL coal_first: got %h valid %b want 1 valid 1", a_cmd, a_valid);
    end
    wr(2'd2, 32'h5, 4'hF);
    wr(2'd2, 32'h9, 4'hF);
    total++;
    if (a_valid !== 1'b1 || a_cmd !== 32'h1) begin
      bad++; $display("FAIL coal_stable: got %h valid %b want 1 valid 1", a_cmd, a_valid);
    end
    ack();
    total++;
    if (a_valid !== 1'b0) begin bad++; $display("FAIL coal_ack1: got %b want 0", a_valid); end
    step();
    total++;
    if (a_valid !== 1'b1 || a_cmd !== 32'h9) begin
      bad++; $display("FAIL coal_second: got %h valid %b want 9 valid 1", a_cmd, a_valid);
    end
    ack();
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (a_valid) extra++;
    end
    total++;
    if (extra != 0) begin bad++; $display("FAIL coal_extra_cmds: got %0d cycles valid want 0", extra); end
    rd(2'd3);
    total++;
    if (a_rd_data !== 32'h1) begin bad++; $display("FAIL coal_cc: got %h want 1", a_rd_data); end
  endtask

  task automatic test_timeout();
    int nv, nt;
    apply_reset();
    wr(2'd2, 32'h1, 4'hF);
    step();
    nv = b_valid ? 1 : 0;
    nt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (b_valid) nv++;
      if (b_timeout) nt++;
    end
    total++;
    if (nv != 8) begin bad++; $display("FAIL timeout_valid_cycles: got %0d want 8", nv); end
    total++;
    if (nt != 1) begin bad++; $display("FAIL timeout_pulses: got %0d want 1", nt); end
    total++;
    if (a_valid !== 1'b1) begin bad++; $display("FAIL timeout_a_still_busy: got %b want 1", a_valid); end
    rd(2'd3);
    total++;
    if (b_rd_data !== 32'h1) begin bad++; $display("FAIL timeout_cc: got %h want 1", b_rd_data); end
  endtask

  task automatic test_ack_w1c_race();
    apply_reset();
    wr(2'd2, 32'h1, 4'hF);
    step();
    ready = 1'b1;
    wr(2'd3, 32'h1, 4'h1);
    ready = 1'b0;
    rd(2'd3);
    total++;
    if (a_rd_data !== 32'h1) begin bad++; $display("FAIL race_cc_a: got %h want 1", a_rd_data); end
    total++;
    if (b_rd_data !== 32'h1) begin bad++; $display("FAIL race_cc_b: got %h want 1", b_rd_data); end
  endtask

  task automatic test_reset_mid_busy();
    int nv;
    apply_reset();
    wr(2'd2, 32'h3, 4'hF);
    step();
    rd_en = 1'b1; addr = 2'd2;
    step();
    rd_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({a_rd_data, a_rd_valid, a_cmd, a_valid, a_timeout} !== 98'h0) begin
      bad++; $display("FAIL async_reset_a: got %h want 0", {a_rd_data, a_rd_valid, a_cmd, a_valid, a_timeout});
    end
    total++;
    if ({b_rd_data, b_rd_valid, b_cmd, b_valid, b_timeout} !== 98'h0) begin
      bad++; $display("FAIL async_reset_b: got %h want 0", {b_rd_data, b_rd_valid, b_cmd, b_valid, b_timeout});
    end
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (a_valid || b_valid) nv++;
    end
    total++;
    if (nv != 0) begin bad++; $display("FAIL post_reset_cmd: got %0d valid cycles want 0", nv); end
    rd(2'd2);
    total++;
    if (a_rd_data !== 32'h0) begin bad++; $display("FAIL post_reset_ctrl: got %h want 0", a_rd_data); end
    rd(2'd3);
    total++;
    if (a_rd_data !== 32'h0 || b_rd_data !== 32'h0) begin
      bad++; $display("FAIL post_reset_cc: got %h/%h want 0/0", a_rd_data, b_rd_data);
    end
  endtask

  task automatic test_random();
    logic [31:0] m_a, m_b, d, exp_a, exp_b, a_last, b_last, pa_cmd, pb_cmd;
    logic [3:0]  e;
    logic [1:0]  ad;
    logic        kicked, pa_valid, pb_valid;
    apply_reset();
    m_a = 0; m_b = 0; a_last = 0; b_last = 0; kicked = 0;
    pa_valid = 0; pb_valid = 0; pa_cmd = 0; pb_cmd = 0;
    for (int i = 0; i < 320; i++) begin
      if (i >= 280) begin
        ready = 1'b1;
        step();
      end else begin
        ready = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 2) != 0) begin
          d = $urandom;
          e = 4'($urandom_range(0, 15));
          wr(2'd2, d, e);
          m_a = apply_wr(m_a, d, e, A_WM);
          m_b = apply_wr(m_b, d, e, B_WM);
          if (e[1:0] != 2'b00) kicked = 1'b1;
        end else begin
          next_off = 12'($urandom);
          ad = 2'($urandom_range(0, 2));
          rd(ad);
          case (ad)
            2'd0:    begin exp_a = {next_off, 4'h1, 16'h0029}; exp_b = exp_a; end
            2'd1:    begin exp_a = A_WM; exp_b = B_WM; end
            default: begin exp_a = m_a & A_RM; exp_b = m_b & B_RM; end
          endcase
          total++;
          if (a_rd_data !== exp_a || a_rd_valid !== 1'b1) begin
            bad++; $display("FAIL rand_rd_a addr %0d: got %h want %h", ad, a_rd_data, exp_a);
          end
          total++;
          if (b_rd_data !== exp_b || b_rd_valid !== 1'b1) begin
            bad++; $display("FAIL rand_rd_b addr %0d: got %h want %h", ad, b_rd_data, exp_b);
          end
        end
      end
      if (pa_valid && a_valid) begin
        total++;
        if (a_cmd !== pa_cmd) begin bad++; $display("FAIL rand_stable_a: got %h want %h", a_cmd, pa_cmd); end
      end
      if (pb_valid && b_valid) begin
        total++;
        if (b_cmd !== pb_cmd) begin bad++; $display("FAIL rand_stable_b: got %h want %h", b_cmd, pb_cmd); end
      end
      if (b_valid) begin
        total++;
        if ((b_cmd & ~B_WM) !== 32'h0) begin bad++; $display("FAIL rand_cmd_bits_b: got %h", b_cmd); end
      end
      if (a_valid) a_last = a_cmd;
      if (b_valid) b_last = b_cmd;
      pa_valid = a_valid; pb_valid = b_valid; pa_cmd = a_cmd; pb_cmd = b_cmd;
    end
    ready = 1'b0;
    if (kicked) begin
      total++;
      if (a_last !== m_a) begin bad++; $display("FAIL rand_last_cmd_a: got %h want %h", a_last, m_a); end
      total++;
      if (b_last !== m_b) begin bad++; $display("FAIL rand_last_cmd_b: got %h want %h", b_last, m_b); end
      rd(2'd3);
      total++;
      if (a_rd_data !== 32'h1 || b_rd_data !== 32'h1) begin
        bad++; $display("FAIL rand_cc: got %h/%h want 1/1", a_rd_data, b_rd_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_header_read();
    test_ctrl_write();
    test_coalesce();
    test_timeout();
    test_ack_w1c_race();
    test_reset_mid_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
